// File: rtl/mul_pkg.sv
// Shared encodings for the multiply issue controller.
// Op codes, FSM state type, default widths, op decode helpers.
package mul_pkg;

  localparam int XLEN_D  = 32;
  localparam int TAG_W_D = 5;

  localparam logic [1:0] OP_MUL_W   = 2'b00;
  localparam logic [1:0] OP_MULH_W  = 2'b01;
  localparam logic [1:0] OP_MULH_WU = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  function automatic logic op_high(
    input logic [1:0] op
  );
    return (op == OP_MULH_W) ||
           (op == OP_MULH_WU);
  endfunction

  function automatic logic op_signed(
    input logic [1:0] op
  );
    return op != OP_MULH_WU;
  endfunction

endpackage

// File: rtl/mul.sv
// Iterative shift-add multiplier, one product bit per cycle.
// Ports: clk, resetn (sync, active-low), start, signed_mode, a, b -> busy, done, product.
module mul
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              fin;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     sum;

  // Signed operands are multiplied as magnitudes; the sign is
  // applied in one extra cycle once all bits are consumed.
  assign a_neg = signed_mode & a[XLEN-1];
  assign b_neg = signed_mode & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} +
               (acc[0] ? {1'b0, mcand} : '0);

  assign product = acc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      fin   <= 1'b0;
      neg   <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy  <= 1'b1;
          fin   <= 1'b0;
          cnt   <= '0;
          neg   <= a_neg ^ b_neg;
          mcand <= mag_a;
          acc   <= {{XLEN{1'b0}}, mag_b};
        end
      end else if (fin) begin
        busy <= 1'b0;
        fin  <= 1'b0;
        done <= 1'b1;
        if (neg) acc <= -acc;
      end else begin
        acc <= {sum, acc[XLEN-1:1]};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(XLEN - 1)) fin <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller wrapping the iterative multiplier with valid/ready
// handshakes, flush/drain and a registered result. Ports: clk, reset,
// in_* request, flush, out_* result, busy.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int TAG_W = TAG_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_dest,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_dest,
  output logic             busy
);

  state_t            state;
  state_t            state_n;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;
  logic              start;
  logic              m_busy;
  logic              m_done;
  logic [2*XLEN-1:0] m_prod;

  assign in_ready = ((state == IDLE) ||
                     (state == HOLD && out_ready)) &&
                    !flush;
  assign accept   = in_valid && in_ready;
  // Accept only happens with the multiplier idle; the gate
  // makes a double start structurally impossible.
  assign start    = accept && !m_busy;
  assign busy     = state != IDLE;

  mul #(
    .XLEN(XLEN)
  ) u_mul (
    .clk        (clk),
    .resetn     (~reset),
    .start      (start),
    .signed_mode(op_signed(in_op)),
    .a          (in_src1),
    .b          (in_src2),
    .busy       (m_busy),
    .done       (m_done),
    .product    (m_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = WAIT;
      WAIT: begin
        // A flush coinciding with done has nothing left to drain.
        if (flush)       state_n = m_done ? IDLE : DRAIN;
        else if (m_done) state_n = HOLD;
      end
      HOLD: begin
        if (flush)          state_n = IDLE;
        else if (out_ready) state_n = accept ? WAIT : IDLE;
      end
      DRAIN: if (m_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      tag_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
    end else begin
      if (accept) begin
        op_q  <= in_op;
        tag_q <= in_dest;
      end
      if (state == WAIT && m_done && !flush) begin
        out_valid  <= 1'b1;
        out_result <= op_high(op_q) ?
                      m_prod[2*XLEN-1:XLEN] :
                      m_prod[XLEN-1:0];
        out_dest   <= tag_q;
      end else if (state == HOLD &&
                   (flush || out_ready)) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl.
// Scoreboard of expected results keyed on accept, checked on output.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = XLEN + 3;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] dest;
    int               due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_dest;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_dest;
  logic             busy;

  exp_t            q[$];
  logic [XLEN-1:0] drv_exp;
  int              tests = 0;
  int              fails = 0;
  int              ncyc  = 0;
  bit              seen  = 0;

  mul_issue_ctrl #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_dest   (in_dest),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_dest  (out_dest),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(
    input logic [1:0] op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [2*XLEN-1:0] ps;
    logic [2*XLEN-1:0]        pu;
    case (op)
      2'b01: begin
        ps = $signed({{XLEN{a[XLEN-1]}}, a}) *
             $signed({{XLEN{b[XLEN-1]}}, b});
        return ps[2*XLEN-1:XLEN];
      end
      2'b10: begin
        pu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return pu[2*XLEN-1:XLEN];
      end
      default: return a * b;
    endcase
  endfunction

  // Scoreboard: push on accept, compare while valid, pop on
  // handshake, discard on flush, clear on reset.
  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      q.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: result %h dest %0d, none pending",
                   out_result, out_dest);
        end else begin
          tests++;
          if (out_result !== q[0].res || out_dest !== q[0].dest) begin
            fails++;
            $display("FAIL result: got %h/%0d want %h/%0d",
                     out_result, out_dest, q[0].res, q[0].dest);
          end
          if (!seen) begin
            seen = 1;
            tests++;
            if (ncyc != q[0].due) begin
              fails++;
              $display("FAIL latency: valid at cycle %0d want %0d",
                       ncyc, q[0].due);
            end
          end
        end
      end
      if (flush) begin
        if (q.size() > 0) q.delete(0);
        seen = 0;
      end else if (out_valid && out_ready && q.size() > 0) begin
        q.delete(0);
        seen = 0;
      end
      if (in_valid && in_ready)
        q.push_back('{drv_exp, in_dest, ncyc + LAT});
    end
  end

  task automatic issue(
    input logic [1:0] op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [TAG_W-1:0] d,
    input logic [XLEN-1:0] e,
    output int waits
  );
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_dest  = d;
    drv_exp  = e;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready %b after %0d cycles want 1",
               in_ready, waits);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: pending %0d busy %b want 0/0",
               q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL valid_timeout: out_valid %b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests += 4;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    if (out_result !== '0) begin
      fails++; $display("FAIL rst_result: got %h want 0", out_result);
    end
    if (out_dest !== '0) begin
      fails++; $display("FAIL rst_dest: got %h want 0", out_dest);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    int w;
    out_ready = 1'b1;
    issue(OP_MUL_W, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, w);
    wait_idle(100);
    issue(OP_MULH_W, 32'h8000_0000, 32'h8000_0000, 5'd10,
          32'h4000_0000, w);
    wait_idle(100);
    issue(OP_MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17,
          32'hFFFF_FFFE, w);
    wait_idle(100);
    issue(OP_RSVD, 32'd5, 32'd6, 5'd31, 32'd30, w);
    wait_idle(100);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    out_ready = 1'b0;
    issue(OP_MULH_W, a, b, 5'd7, model(OP_MULH_W, a, b), w);
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL hold_stall: ready/valid %b/%b want 0/1",
                 in_ready, out_valid);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(OP_MUL_W, 32'h1234, 32'h10, 5'd9, 32'h12340, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("FAIL b2b_accept: waited %0d want 0", w);
    end
    wait_idle(100);
  endtask

  task automatic test_flush_wait();
    int w;
    out_ready = 1'b1;
    issue(OP_MUL_W, 32'd11, 32'd13, 5'd2, 32'd143, w);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL drain_busy: got %b want 1", busy);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_exit: busy/valid %b/%b want 0/0",
               busy, out_valid);
    end
    @(posedge clk);
    #1;
    issue(OP_MULH_W, 32'hFFFF_FFF0, 32'h0000_0100, 5'd6,
          32'hFFFF_FFFF, w);
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b1;
    issue(OP_MULH_WU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd12,
          model(OP_MULH_WU, 32'hDEAD_BEEF, 32'hCAFE_F00D), w);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_result !== '0 ||
        out_dest !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: v/r/d/b %b/%h/%h/%b want 0/0/0/0",
               out_valid, out_result, out_dest, busy);
    end
    issue(OP_MULH_W, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("FAIL post_reset_accept: waited %0d want 0", w);
    end
    wait_idle(100);
  endtask

  task automatic test_flush_hold();
    int w;
    out_ready = 1'b0;
    issue(OP_MUL_W, 32'd100, 32'd200, 5'd21, 32'd20000, w);
    wait_valid(100);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_op     = OP_MUL_W;
    in_src1   = 32'd3;
    in_src2   = 32'd3;
    in_dest   = 5'd1;
    drv_exp   = 32'd9;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold: valid/busy %b/%b want 0/0",
               out_valid, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int w;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      issue(op, a, b, 5'(i + 20), model(op, a, b), w);
      wait_idle(100);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_src1   = '0;
    in_src2   = '0;
    in_dest   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drv_exp   = '0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush_wait();
    test_reset_mid();
    test_flush_hold();
    test_random();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width.
REQ-002 SHALL have parameter: TAG_W, 5, destination-register tag width.
REQ-003 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: in_valid  in  1  upstream request valid.
REQ-006 SHALL have port: in_ready  out  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port: in_op  in  2  00=MUL_W (low, signed), 01=MULH_W (high, signed), 10=MULH_WU (high, unsigned), 11=reserved, treated as MUL_W.
REQ-008 SHALL have port: in_src1 / in_src2  in  XLEN  operands.
REQ-009 SHALL have port: in_dest  in  TAG_W  tag, passed through unchanged.
REQ-010 SHALL have port: flush  in  1  cancel the in-flight operation.
REQ-011 SHALL have port: out_valid  out  1  result valid.
REQ-012 SHALL have port: out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port: out_result  out  XLEN  selected product half.
REQ-014 SHALL have port: out_dest  out  TAG_W  tag of the result.
REQ-015 SHALL have port: busy  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, WAIT, HOLD and DRAIN.
REQ-017 SHALL assert in_ready = (IDLE || (HOLD && out_ready)) && !flush.
REQ-018 SHALL, on accept, pulse the multiplier start for one cycle with signed_mode = (op != MULH_WU), latch op and tag, and enter WAIT.
REQ-019 SHALL, in WAIT on multiplier done, register the product low half (MUL_W/reserved) or high half (MULH_W/MULH_WU) into out_result, set out_valid and enter HOLD.
REQ-020 SHALL give latency from accept edge T to first out_valid cycle of exactly XLEN+2 cycles (T+34 for XLEN=32).
REQ-021 SHALL, in HOLD, keep out_result/out_dest stable while out_valid && !out_ready.
REQ-022 SHALL, in HOLD on handshake, go to WAIT if a new request is accepted in the same cycle, else to IDLE; out_valid drops the next cycle unless a new result arrives.
REQ-023 SHALL, on flush in WAIT, enter DRAIN; DRAIN waits for the multiplier done, discards the product without asserting out_valid, then goes to IDLE.
REQ-024 SHALL, on flush in HOLD, clear out_valid next cycle and go to IDLE; flush overrides out_ready.
REQ-025 SHALL treat flush in IDLE as no-op; in_ready is low that cycle, so nothing is accepted.
REQ-026 SHALL never start the multiplier while it is busy; at most one operation is in flight.

Reset
REQ-027 SHALL, with reset high at a rising edge, go to IDLE with out_valid=0, out_result=0, out_dest=0 and busy=0, including mid-operation.
REQ-028 SHALL drive the multiplier's active-low resetn from ~reset so that an in-flight multiply is abandoned and its done never reaches the block.
REQ-029 SHALL accept a request in the first cycle after reset is deasserted.

Structure
REQ-030 SHALL define op encodings, state encoding and default XLEN/TAG_W in shared package mul_pkg.
REQ-031 SHALL instantiate the existing iterative multiplier mul (XLEN) as its single sub-module; no other arithmetic is permitted.

Verification
REQ-032 SHALL cover: MUL_W 7 × 0xFFFFFFFD, dest 3 -> out_result 0xFFFFFFEB, out_dest 3, out_valid at T+34.
REQ-033 SHALL cover: MULH_W 0x80000000 × 0x80000000 -> 0x40000000; MULH_WU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; op 11 with 5 × 6 -> 30.
REQ-034 SHALL cover: out_ready low for 10 cycles in HOLD -> result and tag stable and in_ready low; then out_ready=1 with in_valid=1 -> back-to-back accept and second result at that edge+34.
REQ-035 SHALL cover: flush at T+5 -> no out_valid ever for that op, busy high until the DRAIN exit cycle, then IDLE; the next op is correct.
REQ-036 SHALL cover: reset at T+10 -> all outputs zero next cycle; a fresh MULH_W 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-037 SHALL cover: flush asserted in the same cycle as out_ready in HOLD -> out_valid cleared and no new accept.
